cfa_window_buffer: RTL and testbench

- Downstream stage of the CFA window address generator.
- Takes the per-sample issue strobes from that generator and the matching pixel read data from the frame RAM.
- Zero-pads out-of-frame samples and assembles columns, top to bottom, into a FILTER_SIZE x FILTER_SIZE sliding window register array.
- Presents one complete window per committed column to the demosaic kernel, with a one-cycle valid pulse.

---
 rtl/cfa_window_buffer.sv | 131 +++++++++++++
 tb/tb_cfa_window_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cfa_window_buffer.sv
// CFA window buffer: aligns issue strobes with RAM read data, zero-pads out-of-frame
// samples and assembles a FILTER_SIZE x FILTER_SIZE sliding window. Option macro: CFA_PAD_VALUE_EN.
module cfa_window_buffer #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int FILTER_SIZE  = 5,
  parameter int READ_LATENCY = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           sampleValid,
  input  logic                                           addressValid,
  input  logic                                           rowStart,
  input  logic [PIXEL_WIDTH-1:0]                         memData,
`ifdef CFA_PAD_VALUE_EN
  input  logic [PIXEL_WIDTH-1:0]                         padValue,
`endif
  output logic [FILTER_SIZE*FILTER_SIZE*PIXEL_WIDTH-1:0] winOut,
  output logic                                           winValid,
  output logic [15:0]                                    winCount,
  output logic                                           protocolErr
);

  localparam int CW   = $clog2(FILTER_SIZE + 1);
  localparam int COLW = FILTER_SIZE * PIXEL_WIDTH;
  localparam int WINW = FILTER_SIZE * COLW;
  localparam int STGW = (FILTER_SIZE - 1) * PIXEL_WIDTH;
  localparam logic [CW-1:0] LASTROW = CW'(FILTER_SIZE - 1);
  localparam logic [CW-1:0] FULL    = CW'(FILTER_SIZE);

  logic [READ_LATENCY-1:0] sv_pipe_q, av_pipe_q, rs_pipe_q;
  logic [STGW-1:0]         stage_q, stage_d;
  logic [WINW-1:0]         win_q, win_d;
  logic [CW-1:0]           rowIdx_q, rowIdx_d;
  logic [CW-1:0]           colCount_q, colCount_d;
  logic [CW-1:0]           col_inc_s;
  logic                    valid_q, valid_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    arr_v_s, arr_av_s, arr_rs_s;
  logic [PIXEL_WIDTH-1:0]  pad_s, pixel_s;

`ifdef CFA_PAD_VALUE_EN
  assign pad_s = padValue;
`else
  assign pad_s = {PIXEL_WIDTH{1'b0}};
`endif

  assign arr_v_s  = sv_pipe_q[READ_LATENCY-1];
  assign arr_av_s = av_pipe_q[READ_LATENCY-1];
  assign arr_rs_s = rs_pipe_q[READ_LATENCY-1];

  // Next-state logic for column assembly, window shift and status
  always_comb begin
    pixel_s    = arr_av_s ? memData : pad_s;
    stage_d    = stage_q;
    win_d      = win_q;
    rowIdx_d   = rowIdx_q;
    colCount_d = colCount_q;
    valid_d    = 1'b0;
    cnt_d      = cnt_q;
    err_d      = err_q;
    col_inc_s  = (colCount_q == FULL) ? FULL : colCount_q + CW'(1);
    if (arr_v_s) begin
      if (arr_rs_s) begin
        // a rowStart mid-column drops the partial column and restarts at row 0
        err_d                  = err_q | (rowIdx_q != {CW{1'b0}});
        colCount_d             = {CW{1'b0}};
        stage_d[PIXEL_WIDTH-1:0] = pixel_s;
        rowIdx_d               = CW'(1);
      end else begin
        for (int r = 0; r < FILTER_SIZE - 1; r++) begin
          stage_d[r*PIXEL_WIDTH +: PIXEL_WIDTH] =
            (rowIdx_q == CW'(r)) ? pixel_s : stage_q[r*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
        if (rowIdx_q == LASTROW) begin
          win_d      = {pixel_s, stage_q, win_q[WINW-1:COLW]};
          rowIdx_d   = {CW{1'b0}};
          colCount_d = col_inc_s;
          if (col_inc_s == FULL) begin
            valid_d = 1'b1;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          rowIdx_d = rowIdx_q + CW'(1);
        end
      end
    end else begin
      rowIdx_d = rowIdx_q;
    end
  end

  // Strobe alignment chain and assembly state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sv_pipe_q  <= {READ_LATENCY{1'b0}};
      av_pipe_q  <= {READ_LATENCY{1'b0}};
      rs_pipe_q  <= {READ_LATENCY{1'b0}};
      stage_q    <= {STGW{1'b0}};
      win_q      <= {WINW{1'b0}};
      rowIdx_q   <= {CW{1'b0}};
      colCount_q <= {CW{1'b0}};
      valid_q    <= 1'b0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      sv_pipe_q[0] <= sampleValid;
      av_pipe_q[0] <= addressValid;
      rs_pipe_q[0] <= rowStart;
      for (int i = 1; i < READ_LATENCY; i++) begin
        sv_pipe_q[i] <= sv_pipe_q[i-1];
        av_pipe_q[i] <= av_pipe_q[i-1];
        rs_pipe_q[i] <= rs_pipe_q[i-1];
      end
      stage_q    <= stage_d;
      win_q      <= win_d;
      rowIdx_q   <= rowIdx_d;
      colCount_q <= colCount_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign winOut      = win_q;
  assign winValid    = valid_q;
  assign winCount    = cnt_q;
  assign protocolErr = err_q;

endmodule

// File: tb/tb_cfa_window_buffer.sv
// Bench for cfa_window_buffer: two instances (READ_LATENCY 1 and 3) share one sample
// stream; a column-history model predicts every output each cycle, plus literal checks.
module tb_cfa_window_buffer;
  localparam int PW = 8;
  localparam int FS = 5;
  localparam int WINW = FS * FS * PW;
`ifdef CFA_PAD_VALUE_EN
  localparam logic [PW-1:0] PAD = 8'h10;
  logic [PW-1:0] padValue = 8'h10;
`else
  localparam logic [PW-1:0] PAD = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst, sv, av, rs;
  logic [PW-1:0] mem1, mem3;
  logic [WINW-1:0] win1, win3;
  logic wv1, wv3, err1, err3;
  logic [15:0] cnt1, cnt3;

  cfa_window_buffer #(.PIXEL_WIDTH(PW), .FILTER_SIZE(FS), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .sampleValid(sv), .addressValid(av), .rowStart(rs), .memData(mem1),
`ifdef CFA_PAD_VALUE_EN
    .padValue(padValue),
`endif
    .winOut(win1), .winValid(wv1), .winCount(cnt1), .protocolErr(err1));

  cfa_window_buffer #(.PIXEL_WIDTH(PW), .FILTER_SIZE(FS), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .sampleValid(sv), .addressValid(av), .rowStart(rs), .memData(mem3),
`ifdef CFA_PAD_VALUE_EN
    .padValue(padValue),
`endif
    .winOut(win3), .winValid(wv3), .winCount(cnt3), .protocolErr(err3));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0, ntotal = 0;
  task automatic check(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // model: all committed pixels in column order, plus the column being assembled
  typedef struct { int at; logic [WINW-1:0] win; logic [15:0] cnt; logic err; logic v; } eff_t;
  eff_t q1[$], q3[$];
  logic [PW-1:0] allpix[$];
  logic [PW-1:0] cur_col[FS];
  int cur_rows = 0, fresh = 0;
  logic m_err = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  logic [PW-1:0] iss_data[int];

  function automatic logic [WINW-1:0] compose();
    logic [WINW-1:0] w = '0;
    int ncols = allpix.size() / FS;
    for (int c = 0; c < FS; c++)
      for (int r = 0; r < FS; r++)
        if (ncols - FS + c >= 0) w[(c*FS+r)*PW +: PW] = allpix[(ncols-FS+c)*FS + r];
    return w;
  endfunction

  function automatic logic [WINW-1:0] mkwin(input int base);
    logic [WINW-1:0] w = '0;
    for (int i = 0; i < FS*FS; i++) w[i*PW +: PW] = PW'(base + i);
    return w;
  endfunction

  task automatic model_sample(input logic a, input logic r, input logic [PW-1:0] d);
    eff_t e;
    logic [PW-1:0] pix = a ? d : PAD;
    e.v = 1'b0;
    if (r) begin
      if (cur_rows != 0) m_err = 1'b1;
      cur_rows = 0;
      fresh = 0;
    end
    cur_col[cur_rows] = pix;
    cur_rows++;
    if (cur_rows == FS) begin
      for (int i = 0; i < FS; i++) allpix.push_back(cur_col[i]);
      cur_rows = 0;
      fresh++;
      if (fresh >= FS) begin e.v = 1'b1; m_cnt++; end
    end
    e.win = compose(); e.cnt = m_cnt; e.err = m_err;
    e.at = cyc + 2; q1.push_back(e);
    e.at = cyc + 4; q3.push_back(e);
  endtask

  task automatic step(input logic s, input logic a, input logic r, input logic [PW-1:0] d);
    sv = s; av = a; rs = r;
    if (rst) begin
      allpix.delete(); cur_rows = 0; fresh = 0; m_err = 1'b0; m_cnt = 16'd0;
    end else if (s) begin
      iss_data[cyc] = d;
      model_sample(a, r, d);
    end
    mem1 = iss_data.exists(cyc-1) ? iss_data[cyc-1] : 8'hEE;
    mem3 = iss_data.exists(cyc-3) ? iss_data[cyc-3] : 8'hEE;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  logic checking_on = 1'b0;
  eff_t x1 = '{0, '0, 16'd0, 1'b0, 1'b0};
  eff_t x3 = '{0, '0, 16'd0, 1'b0, 1'b0};
  int p1 = 0, p3 = 0, last1 = -1, last3 = -1;

  // per-cycle comparison against the model's scheduled effects
  always @(negedge clk) begin
    x1.v = 1'b0; x3.v = 1'b0;
    if (q1.size() > 0 && q1[0].at == cyc) x1 = q1.pop_front();
    if (q3.size() > 0 && q3[0].at == cyc) x3 = q3.pop_front();
    if (checking_on) begin
      check("l1_valid", WINW'(wv1), WINW'(x1.v));
      check("l1_win", win1, x1.win);
      check("l1_cnt", WINW'(cnt1), WINW'(x1.cnt));
      check("l1_err", WINW'(err1), WINW'(x1.err));
      check("l3_valid", WINW'(wv3), WINW'(x3.v));
      check("l3_win", win3, x3.win);
      check("l3_cnt", WINW'(cnt3), WINW'(x3.cnt));
      check("l3_err", WINW'(err3), WINW'(x3.err));
      if (wv1) begin p1++; last1 = cyc; end
      if (wv3) begin p3++; last3 = cyc; end
    end
    if (rst) begin
      q1.delete(); q3.delete();
      x1 = '{0, '0, 16'd0, 1'b0, 1'b0};
      x3 = '{0, '0, 16'd0, 1'b0, 1'b0};
    end
  end

  initial begin
    int last_iss, snap1, snap3;
    rst = 1'b1; sv = 1'b0; av = 1'b0; rs = 1'b0; mem1 = '0; mem3 = '0;
    @(posedge clk); #1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    checking_on = 1'b1;
    check("reset_win", win1, '0);
    check("reset_cnt", WINW'(cnt1), '0);
    check("reset_flags", WINW'({wv1, err1, wv3, err3}), '0);

    // basic window 1..25, then slide by 26..30 and 31..35
    for (int i = 1; i <= 25; i++) begin
      last_iss = cyc;
      step(1'b1, 1'b1, i == 1, PW'(i));
    end
    idle(6);
    check("basic_pulses", WINW'({p1[7:0], p3[7:0]}), WINW'(16'h0101));
    check("basic_lat1", WINW'(last1 - last_iss), WINW'(2));
    check("basic_lat3", WINW'(last3 - last_iss), WINW'(4));
    check("basic_win", win1, mkwin(1));
    check("basic_cnt", WINW'(cnt1), WINW'(1));
    for (int i = 26; i <= 35; i++) step(1'b1, 1'b1, 1'b0, PW'(i));
    idle(6);
    check("slide_win", win1, {mkwin(11)});
    check("slide_cnt", WINW'(cnt3), WINW'(3));

    // row restart with a padded first column
    snap1 = p1; snap3 = p3;
    for (int i = 0; i < 20; i++)
      step(1'b1, !(i < 2), i == 0, (i < 5) ? 8'hAA : PW'(100 + i));
    idle(6);
    check("restart_quiet", WINW'({p1 - snap1, p3 - snap3}), '0);
    for (int i = 20; i < 25; i++) step(1'b1, 1'b1, 1'b0, PW'(100 + i));
    idle(6);
    check("restart_pulse", WINW'(p1 - snap1), WINW'(1));
    check("restart_cnt", WINW'(cnt1), WINW'(4));
    check("pad_rows01", WINW'({win1[PW-1:0], win1[2*PW-1:PW]}), WINW'({PAD, PAD}));
    check("pad_rows234", WINW'(win3[5*PW-1:2*PW]), WINW'(24'hAAAAAA));
    check("no_err_yet", WINW'({err1, err3}), '0);

    // reset mid-frame with reads in flight
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, i == 0, PW'(50 + i));
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("midrst_win", win1 | win3, '0);
    check("midrst_cnt", WINW'({cnt1, cnt3}), '0);

    // stalled stream, alternate cycles idle
    p1 = 0; p3 = 0;
    for (int i = 1; i <= 25; i++) begin
      last_iss = cyc;
      step(1'b1, 1'b1, i == 1, PW'(i));
      if (i != 25) step(1'b0, 1'b1, 1'b1, 8'h77);
    end
    idle(8);
    check("stall_win3", win3, mkwin(1));
    check("stall_win1", win1, mkwin(1));
    check("stall_lat3", WINW'(last3 - last_iss), WINW'(4));
    check("stall_lat1", WINW'(last1 - last_iss), WINW'(2));
    check("stall_cnt", WINW'({cnt1, cnt3}), WINW'(32'h0001_0001));

    // protocol error: rowStart at rowIdx 2
    step(1'b1, 1'b1, 1'b1, 8'd60);
    step(1'b1, 1'b1, 1'b0, 8'd61);
    step(1'b1, 1'b1, 1'b1, 8'd62);
    idle(6);
    check("perr_set", WINW'({err1, err3}), WINW'(2'b11));
    for (int i = 63; i <= 66; i++) step(1'b1, 1'b1, 1'b0, PW'(i));
    idle(6);
    check("perr_sticky", WINW'({err1, err3}), WINW'(2'b11));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
